// File: rtl/cic_interp_var.sv
`default_nettype none
// ============================================================================
// Module   : cic_interp_var
// Brief    : Multi-channel CIC interpolator with run-time factor and output
//            shift. Define CIC_INTERP_VAR_ROUND_EN for round-half-up scaling.
// Revision : 1.0 - initial release
// ============================================================================
module cic_interp_var #(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int CHANNELS   = 2,
  parameter int STAGES     = 5,
  parameter int DELAY      = 1,
  parameter int MAX_FACTOR = 512
) (
  input  logic                                                         i_clock,
  input  logic                                                         i_reset_n,
  input  logic [$clog2(MAX_FACTOR+1)-1:0]                              i_factor,
  input  logic [$clog2(IN_WIDTH+STAGES*$clog2(MAX_FACTOR*DELAY))-1:0]  i_shift,
  input  logic [CHANNELS*IN_WIDTH-1:0]                                 i_data,
  input  logic                                                         i_valid,
  output logic                                                         o_ready,
  output logic [CHANNELS*OUT_WIDTH-1:0]                                o_data,
  output logic                                                         o_valid,
  input  logic                                                         i_ready
);

  localparam int ACC_W = IN_WIDTH + STAGES*$clog2(MAX_FACTOR*DELAY);
  localparam int FW    = $clog2(MAX_FACTOR+1);
  localparam int SW    = $clog2(ACC_W);

  localparam logic signed [ACC_W:0] c_out_max =
    {{(ACC_W-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W:0] c_out_min =
    {{(ACC_W-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  logic [FW-1:0]   r_factor;
  logic [FW-1:0]   r_phase;
  logic [SW-1:0]   r_shift;
  logic            r_valid;
  logic [FW-1:0]   w_factor_clamp;
  logic            w_last;
  logic            w_adv;
  logic            w_accept;
  logic signed [ACC_W:0] w_bias;

  assign w_last   = (r_phase == FW'(r_factor - FW'(1)));
  assign w_adv    = (r_state == S_RUN) && (!r_valid || i_ready);
  assign o_ready  = i_reset_n && ((r_state == S_IDLE) || (w_last && w_adv));
  assign w_accept = i_valid && o_ready;
  assign o_valid  = r_valid;

  always_comb begin
    w_factor_clamp = i_factor;
    if (i_factor == '0)
      w_factor_clamp = FW'(1);
    else if (i_factor > FW'(MAX_FACTOR))
      w_factor_clamp = FW'(MAX_FACTOR);
  end

`ifdef CIC_INTERP_VAR_ROUND_EN
  assign w_bias = (r_shift != '0) ? signed'((ACC_W+1)'(1) << (r_shift - SW'(1))) : '0;
`else
  assign w_bias = '0;
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_factor <= '0;
      r_phase  <= '0;
      r_shift  <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_factor <= w_factor_clamp;
            r_shift  <= i_shift;
            r_phase  <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_adv) begin
            if (w_last) begin
              r_phase <= '0;
              if (!w_accept)
                r_state <= S_IDLE;
            end else begin
              r_phase <= r_phase + FW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_adv)
        r_valid <= 1'b1;
      else if (i_ready)
        r_valid <= 1'b0;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic signed [ACC_W-1:0]     w_tap [STAGES];
    logic signed [ACC_W-1:0]     w_comb_out;
    logic signed [ACC_W-1:0]     r_dly [STAGES][DELAY];
    // r_acc[0] is the zero-stuff register feeding the first integrator
    logic signed [ACC_W-1:0]     r_acc [STAGES+1];
    logic signed [ACC_W:0]       w_round;
    logic signed [ACC_W:0]       w_shifted;
    logic signed [OUT_WIDTH-1:0] w_sat;
    logic signed [OUT_WIDTH-1:0] r_out;

    always_comb begin
      logic signed [ACC_W-1:0] w_run;
      w_run = ACC_W'(signed'(i_data[c*IN_WIDTH +: IN_WIDTH]));
      for (int k = 0; k < STAGES; k++) begin
        w_tap[k] = w_run;
        w_run    = w_run - r_dly[k][DELAY-1];
      end
      w_comb_out = w_run;
    end

    always_comb begin
      w_round   = signed'({r_acc[STAGES][ACC_W-1], r_acc[STAGES]}) + w_bias;
      w_shifted = w_round >>> r_shift;
      w_sat     = w_shifted[OUT_WIDTH-1:0];
      if (w_shifted > c_out_max)
        w_sat = c_out_max[OUT_WIDTH-1:0];
      else if (w_shifted < c_out_min)
        w_sat = c_out_min[OUT_WIDTH-1:0];
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        for (int k = 0; k < STAGES; k++)
          for (int d = 0; d < DELAY; d++)
            r_dly[k][d] <= '0;
        for (int k = 0; k <= STAGES; k++)
          r_acc[k] <= '0;
        r_out <= '0;
      end else begin
        if (w_accept) begin
          for (int k = 0; k < STAGES; k++) begin
            r_dly[k][0] <= w_tap[k];
            for (int d = 1; d < DELAY; d++)
              r_dly[k][d] <= r_dly[k][d-1];
          end
        end

        if (w_adv) begin
          for (int k = 1; k <= STAGES; k++)
            r_acc[k] <= r_acc[k] + r_acc[k-1];
          r_out <= w_sat;
        end

        if (w_accept)
          r_acc[0] <= w_comb_out;
        else if (w_adv)
          r_acc[0] <= '0;
      end
    end

    assign o_data[c*OUT_WIDTH +: OUT_WIDTH] = r_out;
  end

endmodule
`default_nettype wire

// File: tb/tb_cic_interp_var.sv
`default_nettype none
// ============================================================================
// Module   : tb_cic_interp_var
// Brief    : Scoreboard bench for cic_interp_var (N=1 and N=3 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cic_interp_var;

  localparam int A_FW = 5;   // MAX_FACTOR=16
  localparam int A_SW = 5;   // ACC_W=20
  localparam int B_FW = 10;  // MAX_FACTOR=512
  localparam int B_SW = 6;   // ACC_W=43

  typedef struct packed {
    logic        skip;
    logic [15:0] l1;
    logic [15:0] l0;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [A_FW-1:0] a_factor;
  logic [A_SW-1:0] a_shift;
  logic [31:0]     a_data, a_odata;
  logic            a_valid, a_oready, a_ovalid, a_iready;
  logic [B_FW-1:0] b_factor;
  logic [B_SW-1:0] b_shift;
  logic [31:0]     b_data, b_odata;
  logic            b_valid, b_oready, b_ovalid, b_iready;

  cic_interp_var #(
    .IN_WIDTH(16), .OUT_WIDTH(16), .CHANNELS(2), .STAGES(1), .DELAY(1), .MAX_FACTOR(16)
  ) u_dut_a (
    .i_clock(clk), .i_reset_n(rst_n), .i_factor(a_factor), .i_shift(a_shift),
    .i_data(a_data), .i_valid(a_valid), .o_ready(a_oready),
    .o_data(a_odata), .o_valid(a_ovalid), .i_ready(a_iready)
  );

  cic_interp_var #(
    .IN_WIDTH(16), .OUT_WIDTH(16), .CHANNELS(2), .STAGES(3), .DELAY(1), .MAX_FACTOR(512)
  ) u_dut_b (
    .i_clock(clk), .i_reset_n(rst_n), .i_factor(b_factor), .i_shift(b_shift),
    .i_data(b_data), .i_valid(b_valid), .o_ready(b_oready),
    .o_data(b_odata), .o_valid(b_ovalid), .i_ready(b_iready)
  );

  int checks = 0;
  int errors = 0;
  int pushed_a = 0, recv_a = 0, pushed_b = 0, recv_b = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic signed [15:0] last0, last1;
  logic a_rand_en;

  function automatic logic [15:0] scale(input longint raw, input int s);
    longint v;
    v = raw;
`ifdef CIC_INTERP_VAR_ROUND_EN
    if (s > 0) v = v + (64'sd1 <<< (s - 1));
`endif
    v = v >>> s;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // With N=1 each output is the integrator value before the advance: the
  // previous sample once, then the current sample R-1 times.
  task automatic a_send(input logic signed [15:0] x0, input logic signed [15:0] x1,
                        input int r, input int s);
    bit got;
    got = 1'b0;
    a_data  = {x1, x0};
    a_valid = 1'b1;
    for (int t = 0; t < 2000 && !got; t++) begin
      @(negedge clk);
      if (a_oready) begin
        got = 1'b1;
        qa.push_back(exp_t'({1'b0, scale(last1, s), scale(last0, s)}));
        for (int k = 1; k < r; k++)
          qa.push_back(exp_t'({1'b0, scale(x1, s), scale(x0, s)}));
        pushed_a += r;
        last0 = x0;
        last1 = x1;
      end
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL a_accept: no o_ready within 2000 cycles (x0=%0d)", x0);
    end
  endtask

  task automatic a_drain();
    for (int t = 0; t < 5000 && recv_a < pushed_a; t++) @(posedge clk);
    #1;
    chk("a_drain_count", recv_a, pushed_a);
  endtask

  task automatic b_stream(input int n_in, input logic signed [15:0] e0,
                          input logic signed [15:0] e1);
    int n;
    n = 0;
    b_valid = 1'b1;
    for (int t = 0; t < 2000 && n < n_in; t++) begin
      @(negedge clk);
      if (b_oready) begin
        n++;
        for (int k = 0; k < 8; k++) begin
          qb.push_back(exp_t'({pushed_b < 30, e1, e0}));
          pushed_b++;
        end
      end
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    chk("b_accepts", n, n_in);
    for (int t = 0; t < 2000 && recv_b < pushed_b; t++) @(posedge clk);
    #1;
    chk("b_drain_count", recv_b, pushed_b);
  endtask

  always @(posedge clk) begin
    #1;
    a_iready = a_rand_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n && a_ovalid && a_iready) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_extra_output: got %h with empty scoreboard", a_odata);
      end else begin
        exp_t e;
        e = qa.pop_front();
        if (a_odata !== {e.l1, e.l0}) begin
          errors++;
          $display("FAIL a_out[%0d]: got l0=%0d l1=%0d, expected l0=%0d l1=%0d", recv_a,
                   $signed(a_odata[15:0]), $signed(a_odata[31:16]),
                   $signed(e.l0), $signed(e.l1));
        end
      end
      recv_a++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_ovalid && b_iready) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_extra_output: got %h with empty scoreboard", b_odata);
      end else begin
        exp_t e;
        e = qb.pop_front();
        if (!e.skip) begin
          checks++;
          if (b_odata !== {e.l1, e.l0}) begin
            errors++;
            $display("FAIL b_out[%0d]: got l0=%0d l1=%0d, expected l0=%0d l1=%0d", recv_b,
                     $signed(b_odata[15:0]), $signed(b_odata[31:16]),
                     $signed(e.l0), $signed(e.l1));
          end
        end
      end
      recv_b++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic signed [15:0] tv0 [8];
    logic signed [15:0] tv1 [8];
    tv0 = '{16'sd1000, -16'sd2000, 16'sd32767, -16'sd32768, 16'sd5, -16'sd5, 16'sd123, 16'sd0};
    tv1 = '{-16'sd1, 16'sd77, -16'sd32768, 16'sd32767, 16'sd0, 16'sd300, -16'sd123, 16'sd9};

    rst_n = 1'b0;
    a_valid = 1'b0; a_data = '0; a_factor = '0; a_shift = '0; a_iready = 1'b1;
    b_valid = 1'b0; b_data = '0; b_factor = '0; b_shift = '0; b_iready = 1'b1;
    a_rand_en = 1'b0;
    last0 = '0;
    last1 = '0;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_a_valid", a_ovalid, 0);
    chk("rst_a_ready", a_oready, 0);
    chk("rst_a_data",  a_odata,  0);
    chk("rst_b_valid", b_ovalid, 0);
    chk("rst_b_data",  b_odata,  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_a_ready", a_oready, 1);
    chk("idle_b_ready", b_oready, 1);

    // N=3, R=8 DC: gain 64 saturates at S=0, normalises at S=6
    b_factor = 10'd8;
    b_shift  = 6'd0;
    b_data   = {-16'sd1000, 16'sd1000};
    b_stream(6, 16'sd32767, -16'sd32768);
    b_shift  = 6'd6;
    b_stream(2, 16'sd1000, -16'sd1000);

    // Impulse, R=4: lane0 100 held four times then zeros; factor change mid-burst ignored
    a_factor = 5'd4;
    a_shift  = 5'd0;
    a_send(16'sd100, -16'sd7, 4, 0);
    a_factor = 5'd9;
    a_send(16'sd0, -16'sd7, 4, 0);
    a_send(16'sd0, -16'sd7, 4, 0);
    a_drain();

    // Factor clamp: 0 -> R=1, 21 -> R=16
    a_factor = 5'd0;
    a_send(16'sd11, -16'sd22, 1, 0);
    a_send(16'sd33, -16'sd44, 1, 0);
    a_drain();
    a_factor = 5'd21;
    a_send(16'sd200, -16'sd200, 16, 0);
    a_factor = 5'd2;
    a_send(16'sd0, 16'sd0, 16, 0);
    a_drain();

    // Rounding vs truncation at S=1 for +3 / -3
    a_factor = 5'd2;
    a_shift  = 5'd1;
    a_send(16'sd3, -16'sd3, 2, 1);
    a_send(-16'sd3, 16'sd3, 2, 1);
    a_send(16'sd0, 16'sd0, 2, 1);
    a_drain();

    // Random backpressure, R=3 S=2 then R=1 S=0
    a_rand_en = 1'b1;
    a_factor = 5'd3;
    a_shift  = 5'd2;
    for (int i = 0; i < 8; i++) begin
      a_send(tv0[i], tv1[i], 3, 2);
      a_factor = 5'd7;
    end
    a_drain();
    a_factor = 5'd1;
    a_shift  = 5'd0;
    for (int i = 0; i < 8; i++) a_send(tv1[i], tv0[i], 1, 0);
    a_drain();
    a_rand_en = 1'b0;
    @(posedge clk); #2;

    // Reset at phase 3 of an R=8 burst, then an identical fresh run
    a_factor = 5'd8;
    a_shift  = 5'd0;
    a_send(16'sd50, -16'sd50, 8, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_a_valid", a_ovalid, 0);
    chk("midrst_a_data",  a_odata,  0);
    chk("midrst_a_ready", a_oready, 0);
    qa.delete();
    pushed_a = 0;
    recv_a   = 0;
    last0    = '0;
    last1    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    a_send(16'sd50, -16'sd50, 8, 0);
    a_send(16'sd0, 16'sd0, 8, 0);
    a_drain();

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
